// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial unsigned subtractor.
//   diff = min - sub - borrow_in (mod 2^parallelism), computed DIGIT bits per
//   cycle over parallelism/DIGIT cycles with a single borrow flop between
//   digits. One operation in flight; valid/ready handshake on both sides.
// Optional feature: define SUB_OVERFLOW_EN to add the signed-overflow port ovf.
module serial_subtractor #(
   parameter int parallelism = 32,
   parameter int DIGIT       = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [parallelism-1:0] min,
   input  logic [parallelism-1:0] sub,
   input  logic                   borrow_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [parallelism-1:0] diff,
   output logic                   borrow_out
`ifdef SUB_OVERFLOW_EN
   ,
   output logic                   ovf
`endif
);

   localparam int N  = parallelism / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   // A digit width that does not tile the operand is a configuration error.
   generate
      if ((parallelism % DIGIT) != 0) begin : g_bad_digit
         $error("serial_subtractor: DIGIT must divide parallelism");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          count_q, count_d;
   logic [parallelism-1:0] min_q, min_d;
   logic [parallelism-1:0] sub_q, sub_d;
   logic                   borrow_q, borrow_d;
   logic [parallelism-1:0] diff_q, diff_d;
   logic                   borrow_out_q, borrow_out_d;
   logic                   ovf_q, ovf_d;

   logic [DIGIT-1:0]       dig_min_s;
   logic [DIGIT-1:0]       dig_sub_s;
   logic [DIGIT-1:0]       dig_diff_s;
   logic                   dig_borrow_s;
   logic                   last_digit_s;

   // One digit of the subtraction: {borrow, d} = min_k - sub_k - borrow.
   always_comb begin
      dig_min_s    = min_q[int'(count_q)*DIGIT +: DIGIT];
      dig_sub_s    = sub_q[int'(count_q)*DIGIT +: DIGIT];
      {dig_borrow_s, dig_diff_s} = {1'b0, dig_min_s} - {1'b0, dig_sub_s}
                                   - {{DIGIT{1'b0}}, borrow_q};
      last_digit_s = (count_q == CW'(N - 1));
   end

   // Next-state and datapath update for the IDLE/RUN/DONE sequence.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      min_d        = min_q;
      sub_d        = sub_q;
      borrow_d     = borrow_q;
      diff_d       = diff_q;
      borrow_out_d = borrow_out_q;
      ovf_d        = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               min_d    = min;
               sub_d    = sub;
               borrow_d = borrow_in;
               count_d  = {CW{1'b0}};
               state_d  = S_RUN;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_RUN: begin
            diff_d[int'(count_q)*DIGIT +: DIGIT] = dig_diff_s;
            borrow_d = dig_borrow_s;
            if (last_digit_s) begin
               count_d      = {CW{1'b0}};
               borrow_out_d = dig_borrow_s;
               // Signed overflow: operand signs differ and the result sign
               // does not match the minuend sign.
               ovf_d        = (min_q[parallelism-1] != sub_q[parallelism-1]) &&
                              (dig_diff_s[DIGIT-1] != min_q[parallelism-1]);
               state_d      = S_DONE;
            end else begin
               count_d      = count_q + CW'(1);
               state_d      = S_RUN;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         count_q      <= {CW{1'b0}};
         min_q        <= {parallelism{1'b0}};
         sub_q        <= {parallelism{1'b0}};
         borrow_q     <= 1'b0;
         diff_q       <= {parallelism{1'b0}};
         borrow_out_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         min_q        <= min_d;
         sub_q        <= sub_d;
         borrow_q     <= borrow_d;
         diff_q       <= diff_d;
         borrow_out_q <= borrow_out_d;
         ovf_q        <= ovf_d;
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign diff       = diff_q;
   assign borrow_out = borrow_out_q;
`ifdef SUB_OVERFLOW_EN
   assign ovf        = ovf_q;
`else
   // Overflow is not reported in this build; the flop is left unobserved.
   logic unused_ovf_s;
   assign unused_ovf_s = ovf_q;
`endif

endmodule
